// File: rtl/pulse_stretch_tx.sv
// Replays single-cycle event strobes as fixed-width high levels with a guaranteed low gap.
// Events that arrive during a replay are queued in a saturating counter; any loss sets a sticky flag.
module pulse_stretch_tx #(
  parameter int unsigned HIGH_CYCLES = 200000,
  parameter int unsigned GAP_CYCLES  = 200000,
  parameter int unsigned CNT_W       = 18,
  parameter int unsigned PEND_W      = 4
) (
  input  logic              o_Clock10MHz,
  input  logic              i_Rst_n,
  input  logic              i_Pulse,
  input  logic              i_Clear,
  output logic              o_Level,
  output logic              o_Busy,
  output logic [PEND_W-1:0] o_Pending,
  output logic              o_Overflow
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StGap  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0]  HighLast = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GapLast  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PendMax  = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              p_prev_q, p_prev_d;
  logic              rise;
  logic              dec;

  assign rise     = i_Pulse & ~p_prev_q;
  assign p_prev_d = i_Pulse;

  // IDLE decides on the registered pending count, never on this cycle's rise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    dec     = 1'b0;
    case (state_q)
      StIdle: begin
        level_d = 1'b0;
        if (pend_q != '0) begin
          state_d = StHigh;
          level_d = 1'b1;
          cnt_d   = '0;
          dec     = 1'b1;
        end
      end
      StHigh: begin
        if (cnt_q == HighLast) begin
          state_d = StGap;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StGap: begin
        level_d = 1'b0;
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        level_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear wins over everything, including an event sampled in the same cycle.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (i_Clear) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end else if (rise && !dec) begin
      if (pend_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (dec && !rise) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge o_Clock10MHz or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pend_q   <= '0;
      level_q  <= 1'b0;
      ovf_q    <= 1'b0;
      p_prev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      p_prev_q <= p_prev_d;
    end
  end

  assign o_Level    = level_q;
  assign o_Pending  = pend_q;
  assign o_Overflow = ovf_q;
  assign o_Busy     = (state_q != StIdle) || (pend_q != '0);

endmodule

// File: tb/tb_pulse_stretch_tx.sv
// Directed bench for pulse_stretch_tx with HIGH_CYCLES=4, GAP_CYCLES=3, PEND_W=2.
module tb_pulse_stretch_tx;

  logic       clk;
  logic       rst_n;
  logic       pulse;
  logic       clear;
  logic       level;
  logic       busy;
  logic [1:0] pending;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  // Output-trace statistics gathered by observe().
  int runs, min_w, max_w, high_len, low_len, min_gap, max_gap, max_pend;
  logic prev_lvl;

  pulse_stretch_tx #(
    .HIGH_CYCLES(4),
    .GAP_CYCLES (3),
    .CNT_W      (18),
    .PEND_W     (2)
  ) dut (
    .o_Clock10MHz(clk),
    .i_Rst_n     (rst_n),
    .i_Pulse     (pulse),
    .i_Clear     (clear),
    .o_Level     (level),
    .o_Busy      (busy),
    .o_Pending   (pending),
    .o_Overflow  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mon_clear();
    runs = 0; min_w = 1000; max_w = 0; high_len = 0; low_len = 0;
    min_gap = 1000; max_gap = 0; max_pend = int'(pending); prev_lvl = level;
  endtask

  // Advance n clocks, sampling 1 ns after each rising edge.
  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (level && !prev_lvl) begin
        runs++;
        if (runs > 1) begin
          if (low_len < min_gap) min_gap = low_len;
          if (low_len > max_gap) max_gap = low_len;
        end
        high_len = 1;
      end else if (level) begin
        high_len++;
      end
      if (!level && prev_lvl) begin
        if (high_len < min_w) min_w = high_len;
        if (high_len > max_w) max_w = high_len;
        low_len = 1;
      end else if (!level) begin
        low_len++;
      end
      if (int'(pending) > max_pend) max_pend = int'(pending);
      prev_lvl = level;
    end
  endtask

  // Drive pattern bit i on pulse for cycle i (LSB first).
  task automatic drive_pattern(input logic [15:0] pat, input int len);
    for (int i = 0; i < len; i++) begin
      pulse = pat[i];
      observe(1);
    end
    pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pulse = 1'b0; clear = 1'b0;
    #3;
    checks++; if (level !== 1'b0) begin errors++; $display("FAIL reset_level got=%b exp=0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    observe(3);
  endtask

  task automatic test_single();
    mon_clear();
    pulse = 1'b1;
    observe(1);
    checks++; if (pending !== 2'd1) begin errors++; $display("FAIL single_pend_k got=%0d exp=1", pending); end
    checks++; if (level !== 1'b0) begin errors++; $display("FAIL single_level_k got=%b exp=0", level); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_k got=%b exp=1", busy); end
    pulse = 1'b0;
    observe(1);
    checks++; if (level !== 1'b1) begin errors++; $display("FAIL single_level_k1 got=%b exp=1", level); end
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL single_pend_k1 got=%0d exp=0", pending); end
    observe(3);
    checks++; if (level !== 1'b1) begin errors++; $display("FAIL single_level_k4 got=%b exp=1", level); end
    observe(1);
    checks++; if (level !== 1'b0) begin errors++; $display("FAIL single_level_k5 got=%b exp=0", level); end
    observe(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_k7 got=%b exp=1", busy); end
    observe(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_k8 got=%b exp=0", busy); end
    observe(10);
    checks++; if (runs !== 1) begin errors++; $display("FAIL single_runs got=%0d exp=1", runs); end
    checks++; if (max_w !== 4 || min_w !== 4) begin
      errors++; $display("FAIL single_width got=%0d..%0d exp=4", min_w, max_w);
    end
  endtask

  task automatic test_held();
    mon_clear();
    pulse = 1'b1;
    observe(20);
    pulse = 1'b0;
    observe(10);
    checks++; if (runs !== 1) begin errors++; $display("FAIL held_runs got=%0d exp=1", runs); end
    checks++; if (max_w !== 4 || min_w !== 4) begin
      errors++; $display("FAIL held_width got=%0d..%0d exp=4", min_w, max_w);
    end
    checks++; if (max_pend !== 1) begin errors++; $display("FAIL held_maxpend got=%0d exp=1", max_pend); end
  endtask

  task automatic test_queue();
    mon_clear();
    drive_pattern(16'b0000_0000_0001_0101, 6);
    observe(40);
    checks++; if (runs !== 3) begin errors++; $display("FAIL queue_runs got=%0d exp=3", runs); end
    checks++; if (max_w !== 4 || min_w !== 4) begin
      errors++; $display("FAIL queue_width got=%0d..%0d exp=4", min_w, max_w);
    end
    checks++; if (max_gap !== 4 || min_gap !== 4) begin
      errors++; $display("FAIL queue_gap got=%0d..%0d exp=4", min_gap, max_gap);
    end
    checks++; if (max_pend !== 2) begin errors++; $display("FAIL queue_maxpend got=%0d exp=2", max_pend); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL queue_ovf got=%b exp=0", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL queue_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_saturation();
    mon_clear();
    // Fifth rise lands at k+8 while the FSM is still in GAP and pending is 3.
    drive_pattern(16'b0000_0001_0101_0101, 9);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_set got=%b exp=1", ovf); end
    checks++; if (pending !== 2'd3) begin errors++; $display("FAIL sat_pend got=%0d exp=3", pending); end
    observe(40);
    checks++; if (runs !== 4) begin errors++; $display("FAIL sat_runs got=%0d exp=4", runs); end
    checks++; if (max_pend !== 3) begin errors++; $display("FAIL sat_maxpend got=%0d exp=3", max_pend); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky got=%b exp=1", ovf); end
    clear = 1'b1;
    observe(1);
    clear = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_clear got=%b exp=0", ovf); end
  endtask

  task automatic test_clear_high();
    mon_clear();
    drive_pattern(16'b0000_0000_0001_0101, 5);
    checks++; if (pending !== 2'd2) begin errors++; $display("FAIL clrh_pend_pre got=%0d exp=2", pending); end
    checks++; if (level !== 1'b1) begin errors++; $display("FAIL clrh_level_pre got=%b exp=1", level); end
    clear = 1'b1;
    observe(1);
    clear = 1'b0;
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL clrh_pend got=%0d exp=0", pending); end
    observe(25);
    checks++; if (runs !== 1) begin errors++; $display("FAIL clrh_runs got=%0d exp=1", runs); end
    checks++; if (max_w !== 4) begin errors++; $display("FAIL clrh_width got=%0d exp=4", max_w); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clrh_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_clear_rise();
    mon_clear();
    pulse = 1'b1; clear = 1'b1;
    observe(1);
    pulse = 1'b0; clear = 1'b0;
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL clrr_pend got=%0d exp=0", pending); end
    observe(12);
    checks++; if (runs !== 0) begin errors++; $display("FAIL clrr_runs got=%0d exp=0", runs); end
  endtask

  task automatic test_back_to_back();
    // Rises at k, k+2, k+4, k+6 fill the queue; the rise at k+9 meets the IDLE->HIGH edge.
    drive_pattern(16'b0000_0010_0101_0101, 10);
    checks++; if (pending !== 2'd3) begin errors++; $display("FAIL b2b_pend got=%0d exp=3", pending); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got=%b exp=0", ovf); end
    checks++; if (level !== 1'b1) begin errors++; $display("FAIL b2b_level got=%b exp=1", level); end
    clear = 1'b1;
    observe(1);
    clear = 1'b0;
    observe(20);
  endtask

  task automatic test_async_reset();
    drive_pattern(16'b0000_0000_0000_0101, 4);
    checks++; if (level !== 1'b1 || pending !== 2'd1) begin
      errors++; $display("FAIL arst_pre got=lvl%b/p%0d exp=lvl1/p1", level, pending);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (level !== 1'b0) begin errors++; $display("FAIL arst_level got=%b exp=0", level); end
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL arst_pend got=%0d exp=0", pending); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    observe(2);
    mon_clear();
    pulse = 1'b1;
    observe(1);
    pulse = 1'b0;
    observe(15);
    checks++; if (runs !== 1) begin errors++; $display("FAIL arst_runs got=%0d exp=1", runs); end
    checks++; if (max_w !== 4 || min_w !== 4) begin
      errors++; $display("FAIL arst_width got=%0d..%0d exp=4", min_w, max_w);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_held();
    test_queue();
    test_saturation();
    test_clear_high();
    test_clear_rise();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
